tdm_seq11_det: RTL and testbench
================================

TDM_SEQ11_DET -- requirements
Module: tdm_seq11_det

Interface
REQ-001 SHALL have parameter NCH, default 4, number of serial requester channels (2..8).
REQ-002 SHALL have parameter CW, default 8, width of per-channel match counters.
REQ-003 SHALL have parameter OVERLAP, default 1; 1 = overlapping "11" detection, 0 = non-overlapping.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_b  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ch_valid  input  NCH  per-channel bit-offer request.
REQ-007 SHALL have port ch_bit  input  NCH  per-channel serial data bit, meaningful when ch_valid set.
REQ-008 SHALL have port ch_ready  output  NCH  one-hot-or-zero grant; bit i is consumed when ch_valid[i] and ch_ready[i] are both high.
REQ-009 SHALL have port clr  input  1  synchronous clear of all channel contexts and counters.
REQ-010 SHALL have port match_valid  output  1  one-cycle pulse, registered, marking a detected "11".
REQ-011 SHALL have port match_ch  output  clog2(NCH)  channel index of the match; held at its last value when match_valid is low.
REQ-012 SHALL have port cnt_sel  input  clog2(NCH)  counter readout select.
REQ-013 SHALL have port cnt_out  output  CW  combinational value of the selected channel's match counter.

Function
REQ-014 SHALL share one Mealy "11" evaluation among all channels, one granted bit per cycle.
REQ-015 SHALL keep a 1-bit context per channel: S0 = last accepted bit 0 or none, S1 = last accepted bit 1.
REQ-016 SHALL drive ch_ready combinationally from a round-robin arbiter: grant the first channel with ch_valid set, searching from ptr upward, modulo NCH.
REQ-017 SHALL drive ch_ready to all-zero while clr is high or no channel is requesting.
REQ-018 SHALL, on handshake of channel g, report a match iff context[g]==S1 and ch_bit[g]==1.
REQ-019 SHALL, on handshake, set next context[g] = ch_bit[g], except when OVERLAP=0 and a match occurs, in which case next context[g] = S0.
REQ-020 SHALL leave contexts of non-granted channels unchanged.
REQ-021 SHALL assert match_valid exactly one cycle after the matching handshake, with match_ch = g; latency is 1 clock.
REQ-022 SHALL advance ptr to (g+1) mod NCH only on a handshake; otherwise ptr holds.
REQ-023 SHALL increment counter[g] on each match, saturating at 2^CW-1 with no wrap.
REQ-024 SHALL, on clr, set all contexts to S0, all counters to 0, ptr to 0, and match_valid to 0 next cycle; clr overrides any simultaneous handshake.
REQ-025 SHALL accept a channel whose ch_valid stays high on consecutive cycles only when it is re-granted; a lone requester is granted every cycle.

Reset
REQ-026 SHALL, on rst_b low, asynchronously set contexts to S0, counters to 0, ptr to 0, match_valid to 0, and match_ch to 0.
REQ-027 SHALL discard any in-flight match when reset is asserted mid-operation; no match_valid pulse appears after reset is released.

Structure
REQ-028 SHALL place the S0/S1 state encodings and the default NCH/CW values in a shared package, tdm_seq11_pkg.
REQ-029 SHALL implement arbitration in one sub-module, rr_arbiter (inputs: request vector and ptr; output: one-hot grant and encoded index).

Verification
REQ-030 SHALL cover: reset, then ch0 alone offering 1,1,1 on consecutive cycles with OVERLAP=1 -> match_valid on cycles 3 and 4 after first handshake, match_ch=0, counter[0]=2.
REQ-031 SHALL cover: same stimulus with OVERLAP=0 -> a single match_valid, counter[0]=1.
REQ-032 SHALL cover: all 4 channels valid every cycle with bit=1 -> grants in order 0,1,2,3,0...; first matches appear in the second round, match_ch sequence 0,1,2,3.
REQ-033 SHALL cover: interleaving, with ch1 sending 1, ch2 sending 1, then ch1 sending 1 -> exactly one match, on ch1 (no cross-channel match).
REQ-034 SHALL cover: CW=2 with 5 matches on ch3 -> cnt_out with cnt_sel=3 saturates at 3.
REQ-035 SHALL cover: clr asserted on the same cycle as a matching handshake -> ch_ready=0, no match_valid, all counters 0; and rst_b pulsed mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/tdm_seq11_pkg.sv
// Shared definitions for the time-multiplexed "11" sequence detector:
// per-channel context encoding, default sizes and the context update rule.
package tdm_seq11_pkg;

  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = 8;

  // S0: last accepted bit was 0 (or nothing accepted yet); S1: last was 1.
  typedef enum logic {
    S0 = 1'b0,
    S1 = 1'b1
  } ctx_e;

  // Context after a handshake: follows the accepted bit, except that a
  // non-overlapping detector forgets the trailing 1 of a completed match.
  function automatic ctx_e ctx_next(input logic bit_in, input logic hit, input logic overlap);
    ctx_e nxt;
    if (hit && !overlap) begin
      nxt = S0;
    end else if (bit_in) begin
      nxt = S1;
    end else begin
      nxt = S0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tdm_seq11_det_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping modulo NCH. Produces a one-hot grant and its encoded index.
module rr_arbiter
  import tdm_seq11_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_ptr,
  output logic [NCH-1:0] o_gnt,
  output logic [IW-1:0]  o_idx,
  output logic           o_any
);

  logic [IW-1:0] w_c;

  // Scan channels starting at the pointer; the first active request wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_c = IW'((int'(i_ptr) + k) % NCH);
      if (!o_any && i_req[w_c]) begin
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c;
        o_any      = 1'b1;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/tdm_seq11_det.sv
// Time-multiplexed "11" detector: NCH serial channels share one Mealy
// evaluation, one granted bit per cycle, each channel keeping its own
// 1-bit context and a saturating match counter.
module tdm_seq11_det
  import tdm_seq11_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int CW      = CW_DEF,
  parameter int OVERLAP = 1
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NCH-1:0]           ch_valid,
  input  logic [NCH-1:0]           ch_bit,
  output logic [NCH-1:0]           ch_ready,
  input  logic                     clr,
  output logic                     match_valid,
  output logic [$clog2(NCH)-1:0]   match_ch,
  input  logic [$clog2(NCH)-1:0]   cnt_sel,
  output logic [CW-1:0]            cnt_out
);

  localparam int IW = $clog2(NCH);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  ctx_e            r_ctx [NCH];
  logic [CW-1:0]   r_cnt [NCH];
  logic [IW-1:0]   r_ptr;

  logic [NCH-1:0]  w_req;
  logic [NCH-1:0]  w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_hs;
  logic            w_bit;
  logic            w_match;
  logic [IW-1:0]   w_ptr_nxt;

  // A clear suppresses all requests so nothing is granted that cycle.
  always_comb begin
    w_req = '0;
    if (clr) begin
      w_req = '0;
    end else begin
      w_req = ch_valid;
    end
  end

  rr_arbiter #(
    .NCH (NCH),
    .IW  (IW)
  ) u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_hs)
  );

  assign ch_ready = w_gnt;

  // Shared Mealy evaluation of the granted channel's bit against its context.
  always_comb begin
    w_bit     = ch_bit[w_idx];
    w_match   = w_hs && (r_ctx[w_idx] == S1) && w_bit;
    w_ptr_nxt = '0;
    if (w_idx == IW'(NCH - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_idx + 1'b1;
    end
  end

  // Per-channel context: only the granted channel advances.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NCH; i++) r_ctx[i] <= S0;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) r_ctx[i] <= S0;
    end else if (w_hs) begin
      r_ctx[w_idx] <= ctx_next(w_bit, w_match, OVERLAP != 0);
    end
  end

  // Per-channel match counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else if (w_match && (r_cnt[w_idx] != CNT_MAX)) begin
      r_cnt[w_idx] <= r_cnt[w_idx] + CW'(1);
    end
  end

  // Arbitration pointer and registered match report (match_ch holds between pulses).
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ptr       <= '0;
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else if (clr) begin
      r_ptr       <= '0;
      match_valid <= 1'b0;
    end else begin
      match_valid <= w_match;
      if (w_match) match_ch <= w_idx;
      if (w_hs)    r_ptr    <= w_ptr_nxt;
    end
  end

  // Counter readout; out-of-range selects read as zero.
  always_comb begin
    cnt_out = '0;
    if (int'(cnt_sel) < NCH) begin
      cnt_out = r_cnt[cnt_sel];
    end else begin
      cnt_out = '0;
    end
  end

endmodule

// File: tb/tb_tdm_seq11_det.sv
// Bench for tdm_seq11_det: three instances (overlap, non-overlap, 2-bit
// counters) share one stimulus stream and are compared every cycle against
// an array-based model, plus literal expectations for the directed scenarios.
module tb_tdm_seq11_det;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       clr;
  logic [3:0] ch_valid;
  logic [3:0] ch_bit;
  logic [1:0] cnt_sel;

  logic [3:0] rdy [3];
  logic       mv  [3];
  logic [1:0] mch [3];
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;
  logic [1:0] cnt_c;

  int checks   = 0;
  int failures = 0;

  // model state per instance
  int m_ctx [3][4];
  int m_cnt [3][4];
  int m_ptr [3];
  int m_mv  [3];
  int m_mch [3];
  int ovl   [3] = '{1, 0, 1};
  int cmax  [3] = '{255, 255, 3};

  int pulses [3];
  int mch_log [$];
  logic [3:0] gnt_log [$];

  always #5 clk = ~clk;

  tdm_seq11_det #(.NCH(4), .CW(8), .OVERLAP(1)) dut_a (
    .clk(clk), .rst_b(rst_b), .ch_valid(ch_valid), .ch_bit(ch_bit),
    .ch_ready(rdy[0]), .clr(clr), .match_valid(mv[0]), .match_ch(mch[0]),
    .cnt_sel(cnt_sel), .cnt_out(cnt_a));

  tdm_seq11_det #(.NCH(4), .CW(8), .OVERLAP(0)) dut_b (
    .clk(clk), .rst_b(rst_b), .ch_valid(ch_valid), .ch_bit(ch_bit),
    .ch_ready(rdy[1]), .clr(clr), .match_valid(mv[1]), .match_ch(mch[1]),
    .cnt_sel(cnt_sel), .cnt_out(cnt_b));

  tdm_seq11_det #(.NCH(4), .CW(2), .OVERLAP(1)) dut_c (
    .clk(clk), .rst_b(rst_b), .ch_valid(ch_valid), .ch_bit(ch_bit),
    .ch_ready(rdy[2]), .clr(clr), .match_valid(mv[2]), .match_ch(mch[2]),
    .cnt_sel(cnt_sel), .cnt_out(cnt_c));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Which channel the model says is granted now (-1 = none).
  function automatic int exp_grant(input int k);
    if (clr) return -1;
    for (int j = 0; j < 4; j++) begin
      int c;
      c = (m_ptr[k] + j) % 4;
      if (ch_valid[c]) return c;
    end
    return -1;
  endfunction

  // Model update on each clock edge / reset.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int k = 0; k < 3; k++) begin
        m_ptr[k] = 0; m_mv[k] = 0; m_mch[k] = 0;
        for (int c = 0; c < 4; c++) begin m_ctx[k][c] = 0; m_cnt[k][c] = 0; end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int g;
        int hit;
        g = exp_grant(k);
        if (clr) begin
          m_ptr[k] = 0; m_mv[k] = 0;
          for (int c = 0; c < 4; c++) begin m_ctx[k][c] = 0; m_cnt[k][c] = 0; end
        end else begin
          m_mv[k] = 0;
          if (g >= 0) begin
            hit = (m_ctx[k][g] == 1 && ch_bit[g] == 1'b1) ? 1 : 0;
            if (hit == 1) begin
              m_mv[k] = 1;
              m_mch[k] = g;
              if (m_cnt[k][g] < cmax[k]) m_cnt[k][g] = m_cnt[k][g] + 1;
            end
            m_ctx[k][g] = (hit == 1 && ovl[k] == 0) ? 0 : int'(ch_bit[g]);
            m_ptr[k] = (g + 1) % 4;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    int g;
    int er;
    int ac;
    for (int k = 0; k < 3; k++) begin
      g  = exp_grant(k);
      er = (g < 0) ? 0 : (1 << g);
      chk($sformatf("ready_dut%0d", k), int'(rdy[k]), er);
      chk($sformatf("match_valid_dut%0d", k), int'(mv[k]), m_mv[k]);
      chk($sformatf("match_ch_dut%0d", k), int'(mch[k]), m_mch[k]);
      ac = (k == 0) ? int'(cnt_a) : ((k == 1) ? int'(cnt_b) : int'(cnt_c));
      chk($sformatf("cnt_out_dut%0d", k), ac, m_cnt[k][cnt_sel]);
      if (mv[k] == 1'b1) begin
        pulses[k]++;
        if (k == 0) mch_log.push_back(int'(mch[0]));
      end
    end
  end

  // One stimulus cycle: inputs applied just after a rising edge.
  task automatic cyc(input logic [3:0] v, input logic [3:0] b, input logic c);
    ch_valid = v; ch_bit = b; clr = c;
    #2;
    gnt_log.push_back(rdy[0]);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 3; k++) pulses[k] = 0;
    mch_log.delete();
    gnt_log.delete();
  endtask

  initial begin
    logic [3:0] exp_g [8];
    rst_b = 1'b0; clr = 1'b0; ch_valid = 4'd0; ch_bit = 4'd0; cnt_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_match_valid", int'(mv[0]), 0);
    chk("reset_match_ch", int'(mch[0]), 0);
    chk("reset_cnt", int'(cnt_a), 0);
    rst_b = 1'b1;

    // ch0 alone offers 1,1,1: overlap -> two pulses, non-overlap -> one
    clear_logs();
    cyc(4'b0001, 4'b0001, 1'b0);
    chk("t1_h1_mv_ovl", int'(mv[0]), 0);  chk("t1_h1_mv_novl", int'(mv[1]), 0);
    cyc(4'b0001, 4'b0001, 1'b0);
    chk("t1_h2_mv_ovl", int'(mv[0]), 1);  chk("t1_h2_mv_novl", int'(mv[1]), 1);
    cyc(4'b0001, 4'b0001, 1'b0);
    chk("t1_h3_mv_ovl", int'(mv[0]), 1);  chk("t1_h3_mv_novl", int'(mv[1]), 0);
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("t1_idle_mv_ovl", int'(mv[0]), 0);
    chk("t1_match_ch", int'(mch[0]), 0);
    cnt_sel = 2'd0; #1;
    chk("t1_cnt0_ovl", int'(cnt_a), 2);
    chk("t1_cnt0_novl", int'(cnt_b), 1);

    // all channels requesting with bit 1: round-robin 0..3, matches in round two
    cyc(4'b0000, 4'b0000, 1'b1);
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1111, 4'b1111, 1'b0);
      if (i == 3) chk("t3_no_match_round1", pulses[0], 0);
    end
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 8; i++) chk($sformatf("t3_grant%0d", i), int'(gnt_log[i]), int'(exp_g[i]));
    chk("t3_pulses", pulses[0], 4);
    chk("t3_pulses_novl", pulses[1], 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_match_ch%0d", i), (mch_log.size() > i) ? mch_log[i] : -1, i);

    // interleave ch1=1, ch2=1, ch1=1: only ch1 matches
    cyc(4'b0000, 4'b0000, 1'b1);
    clear_logs();
    cyc(4'b0010, 4'b0010, 1'b0);
    cyc(4'b0100, 4'b0100, 1'b0);
    cyc(4'b0010, 4'b0010, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("t4_pulses", pulses[0], 1);
    chk("t4_pulses_novl", pulses[1], 1);
    chk("t4_match_ch", (mch_log.size() > 0) ? mch_log[0] : -1, 1);

    // six 1s on ch3: 5 matches; 2-bit counter saturates at 3
    cyc(4'b0000, 4'b0000, 1'b1);
    repeat (6) cyc(4'b1000, 4'b1000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cnt_sel = 2'd3; #1;
    chk("t5_cnt3_ovl", int'(cnt_a), 5);
    chk("t5_cnt3_novl", int'(cnt_b), 3);
    chk("t5_cnt3_sat", int'(cnt_c), 3);

    // clr on the same cycle as a matching handshake
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0001, 4'b0001, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b0);
    cnt_sel = 2'd0; #1;
    chk("t6_cnt_before_clr", int'(cnt_a), 1);
    ch_valid = 4'b0001; ch_bit = 4'b0001; clr = 1'b1;
    #1;
    chk("t6_ready_during_clr", int'(rdy[0]), 0);
    @(posedge clk); #1;
    clr = 1'b0; ch_valid = 4'b0000; ch_bit = 4'b0000;
    chk("t6_mv_after_clr", int'(mv[0]), 0);
    chk("t6_cnt_after_clr", int'(cnt_a), 0);

    // reset pulsed while a match is being reported
    clear_logs();
    cyc(4'b0010, 4'b0010, 1'b0);
    cyc(4'b0010, 4'b0010, 1'b0);
    chk("t7_inflight_mv", int'(mv[0]), 1);
    chk("t7_inflight_ch", int'(mch[0]), 1);
    cnt_sel = 2'd1;
    rst_b = 1'b0;
    #1;
    chk("t7_rst_mv", int'(mv[0]), 0);
    chk("t7_rst_mv_novl", int'(mv[1]), 0);
    chk("t7_rst_ch", int'(mch[0]), 0);
    chk("t7_rst_cnt", int'(cnt_a), 0);
    #1;
    rst_b = 1'b1;
    repeat (3) cyc(4'b0000, 4'b0000, 1'b0);
    chk("t7_no_pulse_after_rst", pulses[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
